// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronises and deglitches the raw PS/2 lines,
// decodes 11-bit frames, folds E0/F0 prefixes into flags, and queues
// {ext, rel, scan} events in a first-word-fall-through FIFO.
module ps2_key_fifo #(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk_100mhz,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  logic [1:0]            r_clk_s, r_dat_s;
  logic [FILTER_LEN-1:0] r_clk_sh, r_dat_sh;
  logic                  r_clk_f, r_dat_f;

  state_t                r_state;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_byte;
  logic                  r_par_ok, r_ext, r_rel, r_err;
  logic [TW-1:0]         r_tcnt;

  logic [9:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;

  logic w_fall, w_bit, w_push, w_full, w_empty, w_pop, w_wr;
  logic [9:0] w_push_data;

  // Two-flop synchronisers; lines idle high so they reset to 1.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_data};
    end
  end

  // Shift filter: a level only flips once every sample agrees on the new value.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_clk_sh <= '1;
      r_dat_sh <= '1;
      r_clk_f  <= 1'b1;
      r_dat_f  <= 1'b1;
    end else begin
      r_clk_sh <= {r_clk_sh[FILTER_LEN-2:0], r_clk_s[1]};
      r_dat_sh <= {r_dat_sh[FILTER_LEN-2:0], r_dat_s[1]};
      if (r_clk_sh == '0)      r_clk_f <= 1'b0;
      else if (&r_clk_sh)      r_clk_f <= 1'b1;
      if (r_dat_sh == '0)      r_dat_f <= 1'b0;
      else if (&r_dat_sh)      r_dat_f <= 1'b1;
    end
  end

  // Sample event is the cycle the filtered clock is about to flip 1->0.
  assign w_fall      = r_clk_f && (r_clk_sh == '0);
  assign w_bit       = r_dat_f;
  assign w_push      = w_fall && (r_state == S_STOP) && w_bit && r_par_ok &&
                       (r_byte != 8'hE0) && (r_byte != 8'hF0);
  assign w_push_data = {r_ext, r_rel, r_byte};

  // Frame decoder with inter-edge timeout; frame_err is a registered pulse.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_byte   <= '0;
      r_par_ok <= 1'b0;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
      r_err    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_byte   <= {w_bit, r_byte[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PAR;
          end
          S_PAR: begin
            r_par_ok <= ^{r_byte, w_bit};
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (w_bit && r_par_ok) begin
              if (r_byte == 8'hE0)      r_ext <= 1'b1;
              else if (r_byte == 8'hF0) r_rel <= 1'b1;
              else begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
              end
            end else begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_rel <= 1'b0;
            end
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state <= S_IDLE;
          r_err   <= 1'b1;
          r_ext   <= 1'b0;
          r_rel   <= 1'b0;
          r_tcnt  <= '0;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && evt_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_100mhz) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; overflow is sticky.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign evt_valid  = !w_empty;
  assign evt_data   = w_empty ? 10'd0 : r_mem[r_rptr];
  assign fifo_count = r_count;
  assign frame_err  = r_err;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: frame-level reference model (outcome per frame,
// queue for the FIFO) checked every cycle, plus directed literal checks.
module tb_ps2_key_fifo;
  localparam int FL  = 4;
  localparam int D   = 4;
  localparam int TO  = 300;
  localparam int H   = 12;          // half period of the PS/2 clock in clk cycles
  localparam int LAT = 2 + FL + 1;  // sync + filter + decode-edge latency

  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, evt_ready = 0;
  logic [9:0] evt_data;
  logic evt_valid, frame_err, overflow;
  logic [$clog2(D):0] fifo_count;

  ps2_key_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100mhz(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  typedef struct { int at; int kind; logic [7:0] b; } ev_t;  // kind 1 = error
  ev_t sched[$];
  logic [9:0] q[$];
  logic [9:0] got[$];
  int   cyc = 0, n_cmp = 0, n_bad = 0, errs = 0;
  int   ready_mode = 0, pulse_at = -1;
  bit   m_ext = 0, m_rel = 0, m_ovf = 0, m_err = 0;
  bit   m_pop, m_push, m_full;
  logic [9:0] m_pd;
  ev_t  m_ev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: applies frame outcomes at the cycle the DUT must act on them.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete(); sched.delete();
      m_ext = 0; m_rel = 0; m_ovf = 0; m_err = 0;
    end else begin
      m_err = 0; m_push = 0;
      m_full = (q.size() == D);
      m_pop  = (q.size() != 0) && evt_ready;
      while (sched.size() != 0 && sched[0].at <= cyc) begin
        m_ev = sched.pop_front();
        if (m_ev.kind == 1) begin
          m_err = 1; m_ext = 0; m_rel = 0;
        end else if (m_ev.b == 8'hE0) m_ext = 1;
        else if (m_ev.b == 8'hF0) m_rel = 1;
        else begin
          m_push = 1; m_pd = {m_ext, m_rel, m_ev.b}; m_ext = 0; m_rel = 0;
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) q.push_back(m_pd);
        else m_ovf = 1;
      end
    end
  end

  // Consumer ready driver, changed just after the clock edge.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: evt_ready = 0;
      1: evt_ready = 1;
      2: evt_ready = ($urandom_range(0, 2) == 0);
      default: evt_ready = (cyc + 1 == pulse_at);
    endcase
  end

  // Per-cycle compare against the model; also logs accepted events.
  initial forever begin
    @(posedge clk); #2;
    chk("evt_valid", evt_valid, q.size() != 0);
    if (q.size() != 0) chk("evt_data", evt_data, q[0]);
    chk("fifo_count", fifo_count, q.size());
    chk("frame_err", frame_err, m_err);
    chk("overflow", overflow, m_ovf);
    if (frame_err) errs++;
    if (evt_valid && evt_ready) got.push_back(evt_data);
  end

  task automatic frame(input logic [7:0] b, input bit bp, input bit bs,
                       input int nb, input bit tmo);
    logic [10:0] bits;
    bits = {~bs, (~(^b)) ^ bp, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 0;
      if (i == 10) begin
        sched.push_back('{cyc + LAT, (bp || bs) ? 1 : 0, b});
        pulse_at = cyc + LAT;
      end
      if (i == nb - 1 && tmo) sched.push_back('{cyc + LAT + TO, 1, b});
      repeat (H) @(negedge clk);
      ps2_clk = 1;
    end
    @(negedge clk); ps2_data = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    got.delete();
  endtask

  task automatic chk_got(input string nm, input logic [9:0] a, input int idx);
    if (idx < got.size()) chk(nm, got[idx], a);
    else chk({nm, "_missing"}, got.size(), idx + 1);
  endtask

  initial begin
    int e0;
    logic [7:0] rb;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", frame_err, 0);
    rst = 0; repeat (2) @(negedge clk);

    // Single 0x1C frame.
    ready_mode = 1; got.delete(); e0 = errs;
    frame(8'h1C, 0, 0, 11, 0);
    chk("r030_n", got.size(), 1);
    chk_got("r030_evt", 10'h01C, 0);
    chk("r030_noerr", errs, e0);

    // Prefix folding.
    got.delete();
    frame(8'hF0, 0, 0, 11, 0); frame(8'h1C, 0, 0, 11, 0);
    frame(8'hE0, 0, 0, 11, 0); frame(8'hF0, 0, 0, 11, 0); frame(8'h75, 0, 0, 11, 0);
    frame(8'h1C, 0, 0, 11, 0);
    chk("r031_n", got.size(), 3);
    chk_got("r031_rel", 10'h11C, 0);
    chk_got("r031_extrel", 10'h375, 1);
    chk_got("r031_clr", 10'h01C, 2);

    // Bad parity, then E0 with bad stop bit must not leave ext set.
    got.delete(); e0 = errs;
    frame(8'h1C, 1, 0, 11, 0);
    chk("r032_perr", errs, e0 + 1);
    chk("r032_none", got.size(), 0);
    frame(8'hE0, 0, 1, 11, 0); frame(8'h1C, 0, 0, 11, 0);
    chk("r032_serr", errs, e0 + 2);
    chk_got("r032_evt", 10'h01C, 0);

    // Timeout mid-frame, recovery, then a filtered-out glitch.
    got.delete(); e0 = errs;
    frame(8'h5A, 0, 0, 5, 1);
    repeat (TO + 10) @(negedge clk);
    chk("r035_tmo", errs, e0 + 1);
    frame(8'h1C, 0, 0, 11, 0);
    chk_got("r035_evt", 10'h01C, 0);
    @(negedge clk); ps2_clk = 0; repeat (3) @(negedge clk); ps2_clk = 1;
    repeat (20) @(negedge clk);
    chk("r035_glitch_err", errs, e0 + 1);
    chk("r035_glitch_evt", got.size(), 1);

    // Reset mid-frame abandons it silently.
    got.delete(); e0 = errs;
    frame(8'h33, 0, 0, 5, 0);
    do_reset();
    frame(8'h1C, 0, 0, 11, 0);
    chk("r029_err", errs, e0);
    chk_got("r029_evt", 10'h01C, 0);

    // Overflow with stalled consumer.
    do_reset(); ready_mode = 0;
    frame(8'h15, 0, 0, 11, 0); frame(8'h1D, 0, 0, 11, 0); frame(8'h24, 0, 0, 11, 0);
    frame(8'h2D, 0, 0, 11, 0); frame(8'h2C, 0, 0, 11, 0);
    chk("r033_count", fifo_count, 4);
    chk("r033_ovf", overflow, 1);
    chk("r033_head", evt_data, 10'h015);
    ready_mode = 1; repeat (10) @(negedge clk); ready_mode = 0;
    chk("r033_n", got.size(), 4);
    chk_got("r033_p0", 10'h015, 0); chk_got("r033_p1", 10'h01D, 1);
    chk_got("r033_p2", 10'h024, 2); chk_got("r033_p3", 10'h02D, 3);
    repeat (3) @(negedge clk);
    chk("r033_sticky", overflow, 1);

    // Push and pop together while full.
    do_reset(); ready_mode = 0;
    frame(8'h15, 0, 0, 11, 0); frame(8'h1D, 0, 0, 11, 0);
    frame(8'h24, 0, 0, 11, 0); frame(8'h2D, 0, 0, 11, 0);
    ready_mode = 3;
    frame(8'h2C, 0, 0, 11, 0);
    ready_mode = 0;
    chk("r034_count", fifo_count, 4);
    chk("r034_ovf", overflow, 0);
    chk("r034_head", evt_data, 10'h01D);
    ready_mode = 1; repeat (10) @(negedge clk); ready_mode = 0;
    chk("r034_n", got.size(), 5);
    chk_got("r034_p1", 10'h01D, 1); chk_got("r034_p4", 10'h02C, 4);

    // Random traffic against the model.
    do_reset(); ready_mode = 2;
    for (int k = 0; k < 45; k++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 8'hE0;
      else if ($urandom_range(0, 7) == 0) rb = 8'hF0;
      frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, 11, 0);
    end
    ready_mode = 1; repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, 4, consecutive equal synchronised samples required to change a filtered PS/2 line level (2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, 8, event FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 200000, clk_100mhz cycles allowed between filtered falling edges inside a frame.
REQ-004 SHALL have port clk_100mhz  input  1  sole clock, 100 MHz.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk_100mhz.
REQ-007 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk_100mhz.
REQ-008 SHALL have port evt_data  output  10  FIFO head: bit9 extended (E0), bit8 release (F0), bits7:0 scan code.
REQ-009 SHALL have port evt_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the head this cycle.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.
REQ-012 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through two-flop synchronisers, then a FILTER_LEN shift filter: filtered level flips only when all FILTER_LEN samples equal the opposite value.
REQ-015 SHALL treat a 1->0 transition of filtered clock as a bit-sample event; filtered data sampled that cycle.
REQ-016 SHALL run FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, one state step per sample event.
REQ-017 IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay IDLE, pulse frame_err.
REQ-018 PARITY: accept when XOR of 8 data bits and parity bit = 1 (odd parity); otherwise mark frame bad.
REQ-019 STOP: sample 1 and parity good -> byte complete; else pulse frame_err, discard byte, clear both prefix flags.
REQ-020 In DATA/PARITY/STOP, a cycle counter SHALL reset on each sample event; reaching TIMEOUT_CYCLES -> IDLE, pulse frame_err, clear prefix flags.
REQ-021 Completed byte 0xE0 SHALL set ext flag, 0xF0 SHALL set rel flag; neither is pushed.
REQ-022 Any other completed byte SHALL push {ext, rel, byte} in the cycle of the stop-bit sample event and clear both flags.
REQ-023 FIFO SHALL be first-word-fall-through: evt_data/evt_valid reflect the head the cycle after a push into an empty FIFO.
REQ-024 Pop SHALL occur when evt_valid and evt_ready are both 1; evt_data SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-025 Push while full without pop SHALL drop the new event and set overflow; push and pop in the same cycle while full SHALL both succeed, count unchanged.
REQ-026 Pop when empty SHALL have no effect; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 fifo_count SHALL update the cycle after each push/pop, range 0..FIFO_DEPTH.

Reset
REQ-028 rst=1 SHALL immediately force: FSM IDLE, counters 0, prefix flags 0, FIFO empty, evt_valid 0, evt_data 0, frame_err 0, overflow 0, fifo_count 0, filtered lines and synchronisers 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no event and no frame_err; first frame after release decodes normally.

Verification
REQ-030 Frame 0x1C (bits 0,00111000,parity 0,1), evt_ready=1 -> one event evt_data=0x01C, frame_err never high.
REQ-031 Bytes F0,1C -> single event 0x11C; bytes E0,F0,75 -> single event 0x375; following 1C -> 0x01C (flags cleared).
REQ-032 Byte 0x1C with parity 1 -> frame_err pulse one cycle, no event; then E0 with bad stop bit followed by 1C -> 0x01C.
REQ-033 FIFO_DEPTH=4, evt_ready=0, five codes 15,1D,24,2D,2C -> fifo_count=4, overflow=1, pops return 0x015,0x01D,0x024,0x02D; overflow stays 1 until rst.
REQ-034 Full FIFO, evt_ready=1 in the push cycle -> count stays 4, no overflow, order preserved.
REQ-035 Clock stalls after 4 data bits for TIMEOUT_CYCLES+10 -> frame_err pulse, FSM IDLE; next frame 0x1C -> 0x01C; 3-cycle glitch on ps2_clk (FILTER_LEN=4) -> no bit sampled.
